// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives a variable-latency imem port and buffers words for IF/ID.
// Define FETCH_PERF_CNT_EN to add saturating perf_bubbles / perf_flushes counter ports.

// state   | meaning
// IDLE    | no request outstanding; issues one when a FIFO slot is guaranteed free
// WAIT    | request outstanding, data will be pushed on ack
// DROP    | request outstanding after a redirect, data discarded on ack
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        valid_out,
   output logic [31:0] ins_out,
   output logic [31:0] npc_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_bubbles,
   output logic [31:0] perf_flushes
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DROP
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_addr_q, req_addr_d;
   logic [31:0]   last_npc_q, last_npc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];

   logic [63:0]   head;
   logic [CW-1:0] occupancy;
   logic          push;
   logic          pop;
   logic          can_issue;

   always_comb begin
      head      = mem_q[rd_ptr_q];
      valid_out = (count_q != '0);
      ins_out   = valid_out ? head[63:32] : NOP_WORD;
      npc_out   = valid_out ? head[31:0]  : last_npc_q;
      pop       = valid_out & id_ready & ~redirect;
      occupancy = count_q - CW'(pop);
      // Only issue when the word is certain to find a free slot on arrival.
      can_issue = ~reset & ~redirect & (occupancy < DEPTH_C);
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      imem_req   = 1'b0;
      imem_addr  = req_addr_q;
      push       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            imem_addr = fetch_pc_q;
            imem_req  = can_issue;
            if (can_issue) begin
               req_addr_d = fetch_pc_q;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            imem_req = 1'b1;
            if (redirect) begin
               state_d = imem_ack ? ST_IDLE : ST_DROP;
            end else if (imem_ack) begin
               push       = 1'b1;
               fetch_pc_d = req_addr_q + 32'd4;
               state_d    = ST_IDLE;
            end
         end
         ST_DROP: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end
   end

   always_comb begin
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      last_npc_d = npc_out;

      if (push) begin
         mem_d[wr_ptr_q] = {imem_rdata, req_addr_q + 32'd4};
      end

      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         last_npc_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         last_npc_q <= last_npc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while count_q covers them.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_bubbles_q, perf_bubbles_d;
   logic [31:0] perf_flushes_q, perf_flushes_d;

   always_comb begin
      perf_bubbles_d = perf_bubbles_q;
      perf_flushes_d = perf_flushes_q;
      if (id_ready && !valid_out && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
         perf_bubbles_d = perf_bubbles_q + 32'd1;
      end
      if (redirect && (perf_flushes_q != 32'hFFFF_FFFF)) begin
         perf_flushes_d = perf_flushes_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_bubbles_q <= '0;
         perf_flushes_q <= '0;
      end else begin
         perf_bubbles_q <= perf_bubbles_d;
         perf_flushes_q <= perf_flushes_d;
      end
   end

   assign perf_bubbles = perf_bubbles_q;
   assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: expected IF/ID words queued by the stimulus, checked by a separate monitor.
module tb_if_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        valid_out;
   logic [31:0] ins_out;
   logic [31:0] npc_out;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_bubbles;
   logic [31:0] perf_flushes;
`endif

   // memory: auto responder (fixed 1-cycle latency) or manual drive
   logic        mem_auto;
   logic        auto_ack;
   logic [31:0] auto_rdata;
   logic        man_ack;
   logic [31:0] man_rdata;
   logic [31:0] req_log [$];

   assign imem_ack   = mem_auto ? auto_ack   : man_ack;
   assign imem_rdata = mem_auto ? auto_rdata : man_rdata;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] npc;
   } exp_t;
   exp_t exp_q [$];

   int total = 0;
   int bad   = 0;
   int sb_total = 0;
   int sb_bad   = 0;
   int sb_pops  = 0;

   if_fetch_unit dut (
      .clock       (clock),
      .reset       (reset),
      .id_ready    (id_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .valid_out   (valid_out),
      .ins_out     (ins_out),
      .npc_out     (npc_out)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_bubbles(perf_bubbles),
      .perf_flushes(perf_flushes)
`endif
   );

   always #5 clock = ~clock;

   initial begin : mem_model
      logic        pend;
      logic [31:0] paddr;
      pend       = 1'b0;
      paddr      = '0;
      auto_ack   = 1'b0;
      auto_rdata = '0;
      forever begin
         @(posedge clock);
         #1;
         auto_ack = 1'b0;
         if (reset || !mem_auto) begin
            pend = 1'b0;
         end else if (pend) begin
            auto_ack   = 1'b1;
            auto_rdata = {16'hC0DE, paddr[15:0]};
            pend       = 1'b0;
         end
         @(negedge clock);
         if (mem_auto && !reset && !pend && !auto_ack && imem_req) begin
            pend  = 1'b1;
            paddr = imem_addr;
            req_log.push_back(imem_addr);
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && valid_out && id_ready && !redirect) begin
            sb_pops++;
            sb_total++;
            if (exp_q.size() == 0) begin
               sb_bad++;
               $display("FAIL sb_extra: got ins=%h npc=%h, required no entry", ins_out, npc_out);
            end else begin
               e = exp_q.pop_front();
               if (ins_out !== e.ins || npc_out !== e.npc) begin
                  sb_bad++;
                  $display("FAIL sb_entry: got ins=%h npc=%h, required ins=%h npc=%h",
                           ins_out, npc_out, e.ins, e.npc);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic expect_word(input logic [31:0] ins, input logic [31:0] npc);
      exp_t e;
      e.ins = ins;
      e.npc = npc;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      id_ready    = 1'b0;
      man_ack     = 1'b0;
      man_rdata   = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin : stim
      int base;
      int pbase;
      logic [31:0] t1_addr [4];
      t1_addr[0] = 32'h3000; t1_addr[1] = 32'h3004;
      t1_addr[2] = 32'h3008; t1_addr[3] = 32'h300C;

      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      man_ack = 1'b0; man_rdata = '0; mem_auto = 1'b0;
      tick();
      @(negedge clock);
      check32("rst_req",   32'(imem_req),  32'h0);
      check32("rst_addr",  imem_addr,      32'h0000_3000);
      check32("rst_valid", 32'(valid_out), 32'h0);
      check32("rst_ins",   ins_out,        32'h0);
      check32("rst_npc",   npc_out,        32'h0);

      // streaming with 1-cycle memory, ID always ready
      mem_auto = 1'b1;
      do_reset();
      id_ready = 1'b1;
      base  = req_log.size();
      pbase = sb_pops;
      expect_word(32'hC0DE_3000, 32'h3004);
      expect_word(32'hC0DE_3004, 32'h3008);
      expect_word(32'hC0DE_3008, 32'h300C);
      expect_word(32'hC0DE_300C, 32'h3010);
      repeat (9) tick();
      check32("stream_pops", 32'(sb_pops - pbase), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (req_log.size() > base + i) check32("stream_addr", req_log[base + i], t1_addr[i]);
         else check32("stream_addr_missing", 32'hFFFF_FFFF, t1_addr[i]);
      end
      check32("stream_left", 32'(exp_q.size()), 32'd0);

      // ID stall fills the FIFO, then drains in order
      do_reset();
      base = req_log.size();
      repeat (20) tick();
      @(negedge clock);
      check32("stall_reqs",  32'(req_log.size() - base), 32'd4);
      check32("stall_req0",  32'(imem_req),  32'h0);
      check32("stall_valid", 32'(valid_out), 32'h1);
      check32("stall_npc",   npc_out,        32'h3004);
      check32("stall_ins",   ins_out,        32'hC0DE_3000);
      expect_word(32'hC0DE_3000, 32'h3004);
      expect_word(32'hC0DE_3004, 32'h3008);
      expect_word(32'hC0DE_3008, 32'h300C);
      expect_word(32'hC0DE_300C, 32'h3010);
      tick();
      id_ready = 1'b1;
      repeat (4) tick();
      id_ready = 1'b0;
      check32("drain_left", 32'(exp_q.size()), 32'd0);

      // redirect during WAIT, ack arrives 3 cycles later and is dropped
      mem_auto = 1'b0;
      do_reset();
      id_ready = 1'b1;
      @(negedge clock);
      check32("rdw_req0",  32'(imem_req), 32'h1);
      check32("rdw_addr0", imem_addr,     32'h3000);
      tick();
      redirect = 1'b1; redirect_pc = 32'h0000_4002;
      tick();
      redirect = 1'b0;
      @(negedge clock);
      check32("drop_req",   32'(imem_req),  32'h1);
      check32("drop_addr",  imem_addr,      32'h3000);
      check32("drop_valid", 32'(valid_out), 32'h0);
      tick();
      tick();
      man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
      tick();
      man_ack = 1'b0;
      @(negedge clock);
      check32("rdw_req1",   32'(imem_req),  32'h1);
      check32("rdw_addr1",  imem_addr,      32'h4000);
      check32("rdw_valid1", 32'(valid_out), 32'h0);
      tick();
      man_ack = 1'b1; man_rdata = 32'h1111_4000;
      expect_word(32'h1111_4000, 32'h4004);
      tick();
      man_ack = 1'b0;
      @(negedge clock);
      check32("rdw_valid2", 32'(valid_out), 32'h1);
      check32("rdw_npc2",   npc_out,        32'h4004);
      tick();
      @(negedge clock);
      check32("hold_valid", 32'(valid_out), 32'h0);
      check32("hold_ins",   ins_out,        32'h0);
      check32("hold_npc",   npc_out,        32'h4004);
      check32("rdw_left",   32'(exp_q.size()), 32'd0);

      // redirect in the same cycle as ack
      do_reset();
      id_ready = 1'b1;
      tick();
      man_ack = 1'b1; man_rdata = 32'hBAD0_0001;
      redirect = 1'b1; redirect_pc = 32'h0000_5000;
      tick();
      man_ack = 1'b0; redirect = 1'b0;
      @(negedge clock);
      check32("rda_req",   32'(imem_req),  32'h1);
      check32("rda_addr",  imem_addr,      32'h5000);
      check32("rda_valid", 32'(valid_out), 32'h0);
      tick();
      man_ack = 1'b1; man_rdata = 32'h2222_5000;
      expect_word(32'h2222_5000, 32'h5004);
      tick();
      man_ack = 1'b0;
      tick();
      @(negedge clock);
      check32("rda_valid2", 32'(valid_out), 32'h0);
      check32("rda_npc2",   npc_out,        32'h5004);
      check32("rda_left",   32'(exp_q.size()), 32'd0);

      // reset during WAIT, stale ack right after reset releases
      do_reset();
      id_ready = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      man_ack = 1'b1; man_rdata = 32'hBAD0_0002;
      @(negedge clock);
      check32("rsw_valid", 32'(valid_out), 32'h0);
      check32("rsw_ins",   ins_out,        32'h0);
      check32("rsw_npc",   npc_out,        32'h0);
      check32("rsw_req",   32'(imem_req),  32'h1);
      check32("rsw_addr",  imem_addr,      32'h3000);
      tick();
      man_ack = 1'b0;
      @(negedge clock);
      check32("rsw_valid1", 32'(valid_out), 32'h0);
      check32("rsw_addr1",  imem_addr,      32'h3000);
      tick();
      man_ack = 1'b1; man_rdata = 32'h3333_3000;
      expect_word(32'h3333_3000, 32'h3004);
      tick();
      man_ack = 1'b0;
      @(negedge clock);
      check32("rsw_valid2", 32'(valid_out), 32'h1);
      check32("rsw_npc2",   npc_out,        32'h3004);
      tick();
      check32("rsw_left", 32'(exp_q.size()), 32'd0);

`ifdef FETCH_PERF_CNT_EN
      do_reset();
      id_ready = 1'b1;
      repeat (5) tick();
      id_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h0000_6000;
      repeat (2) tick();
      redirect = 1'b0;
      @(negedge clock);
      check32("perf_bubbles", perf_bubbles, 32'd5);
      check32("perf_flushes", perf_flushes, 32'd2);
`endif

      do_reset();
      tick();
      total = total + sb_total;
      bad   = bad + sb_bad;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
